// File: rtl/mac_op_sequencer.sv
// Control sequencer for the MAC datapath: owns the config word, admits operand beats,
// marks accumulation boundaries and tracks in-flight beats so that config only changes on a drained pipe.

module mac_pipe_stage (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic vld_in,
    input  logic last_in,
    output logic vld,
    output logic last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            last <= 1'b0;
        end else if (adv) begin
            vld  <= vld_in;
            last <= last_in;
        end
    end

endmodule

module mac_op_sequencer #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_PIPE_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg_in,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      op_valid,
    input  logic                      op_last,
    output logic                      op_ready,
    output logic [MAC_CONF_WIDTH-1:0] dp_cfg,
    output logic                      dp_en,
    output logic                      dp_acc_clr,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [MAC_PIPE_DEPTH-1:0] vld_pipe, last_pipe;
    logic                      first;
    logic                      stall;
    logic                      pipe_empty;
    logic                      op_fire;
    logic                      cfg_fire;

    assign res_valid  = vld_pipe[MAC_PIPE_DEPTH-1] & last_pipe[MAC_PIPE_DEPTH-1];
    assign stall      = res_valid & ~res_ready;
    assign dp_en      = en & ~stall;
    assign pipe_empty = (vld_pipe == '0);
    assign op_fire    = op_valid & op_ready;
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign dp_acc_clr = op_fire & first;
    assign busy       = (state != IDLE) | ~pipe_empty;

    // Handshake readies and next state; en gates every transition so en=0 freezes the FSM.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        op_ready  = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = en;
                if (en && cfg_valid) state_nxt = RUN;
            end
            RUN: begin
                op_ready = en & ~stall & ~(cfg_valid & first);
                // A pending config wins over new beats, but only at a boundary.
                if (en && cfg_valid && first) state_nxt = DRAIN;
            end
            DRAIN: begin
                cfg_ready = en & pipe_empty;
                if (en && pipe_empty) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)           dp_cfg <= '0;
        else if (cfg_fire) dp_cfg <= cfg_in;
    end

    always_ff @(posedge clk) begin
        if (rst)          first <= 1'b1;
        else if (op_fire) first <= op_last;
    end

    // Beat tracker: one stage per enabled cycle of datapath latency.
    genvar s;
    generate
        for (s = 0; s < MAC_PIPE_DEPTH; s++) begin : g_stage
            logic vld_in, last_in;
            if (s == 0) begin : g_head
                assign vld_in  = op_fire;
                assign last_in = op_fire & op_last;
            end else begin : g_body
                assign vld_in  = vld_pipe[s-1];
                assign last_in = last_pipe[s-1];
            end
            mac_pipe_stage u_stage (
                .clk     (clk),
                .rst     (rst),
                .adv     (dp_en),
                .vld_in  (vld_in),
                .last_in (last_in),
                .vld     (vld_pipe[s]),
                .last    (last_pipe[s])
            );
        end
    endgenerate

endmodule

// File: doc/mac_op_sequencer.md
Name: mac_op_sequencer

Overview:
- Control block in front of the MAC datapath (negator block → multiplier array → accumulator).
- Owns the datapath configuration word (signed/unsigned, mac/mul, Single/Dual/Quad).
- Admits operand beats with a valid/ready handshake and marks accumulation boundaries (accumulator clear on the first beat, result on the last beat).
- Tracks in-flight beats through a fixed-depth pipeline. A configuration change is applied only after the pipeline has fully drained at an accumulation boundary.

Parameters:
- MAC_CONF_WIDTH, 4, config word width: bit3 signed, bit2 mac/mul, bits[1:0] 00 Single, 01 Dual, 10 Quad (11 treated as Single by the datapath, passed through unchanged).
- MAC_PIPE_DEPTH, 3, datapath latency in enabled cycles from operand acceptance to result at accumulator output (≥1).

Ports:
- clk  in  1  clock. Single clock domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable. When 0, all state frozen and no handshake completes.
- cfg_in  in  MAC_CONF_WIDTH  requested configuration.
- cfg_valid  in  1  configuration change request.
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready & en.
- op_valid  in  1  operand beat available.
- op_last  in  1  beat is the final beat of the current accumulation.
- op_ready  out  1  beat accepted (op_fire) when op_valid & op_ready.
- dp_cfg  out  MAC_CONF_WIDTH  registered configuration driven to the datapath.
- dp_en  out  1  datapath pipeline advance enable.
- dp_acc_clr  out  1  clear the accumulator with this beat; qualified by op_fire.
- res_valid  out  1  accumulator output holds a completed result.
- res_ready  in  1  consumer takes the result.
- busy  out  1  state≠IDLE or any beat in flight.

Behaviour:
- Reset values:
  - state=IDLE, dp_cfg=0, vld_pipe=0, last_pipe=0, first=1.
  - All outputs low except dp_en=en. cfg_ready=en because IDLE is ready.
  - In-flight beats are discarded at reset, including a reset asserted mid-accumulation.
- Pipeline tracking:
  - vld_pipe[D-1:0] and last_pipe[D-1:0] form a shift register that advances only when dp_en=1.
  - Stage 0 loads {op_fire, op_fire&op_last}.
- Result handshake:
  - res_valid = vld_pipe[D-1] & last_pipe[D-1]. This is combinational from registers.
  - Result latency: the last beat fired in cycle t gives res_valid in cycle t+D, provided there are no stalls.
  - stall = res_valid & ~res_ready.
  - dp_en = en & ~stall. A stall freezes the whole pipeline and res_valid holds until accepted.
- Accumulation boundary:
  - first is set at reset and on op_fire&op_last. It is cleared on op_fire&~op_last.
  - dp_acc_clr = op_fire & first.
  - A single-beat accumulation (first and op_last on the same beat) asserts clear and last together.
- FSM:
  - IDLE:
    - cfg_ready=en, op_ready=0.
    - On cfg fire: dp_cfg<=cfg_in, go to RUN.
  - RUN:
    - op_ready = en & ~stall & ~(cfg_valid & first); cfg_ready=0.
    - If cfg_valid & first & en: go to DRAIN. A pending config takes priority over new beats at a boundary.
    - A cfg_valid raised mid-accumulation (first=0) is held off until the last beat is accepted.
  - DRAIN:
    - op_ready=0.
    - cfg_ready = en & (vld_pipe==0). The pipe is empty only once the final result has been accepted.
    - On cfg fire: dp_cfg<=cfg_in, go to RUN.
    - If cfg_valid is withdrawn and the pipe is empty: go to RUN with dp_cfg unchanged.
- Configuration stability: dp_cfg changes only on cfg fire, so it never changes while vld_pipe≠0.
- en=0 in any state: no fire of any kind, registers hold, dp_en=0.

Test Plan:
- Reset, cfg_in=4'b1010 (signed Quad) with cfg_valid → cfg_ready=1 in cycle 0. Then dp_cfg=4'b1010, state RUN, op_ready=1.
- Four-beat accumulation, op_last on beat 4 at cycle t, res_ready=1 → dp_acc_clr only on beat 1, res_valid for exactly one cycle at t+3 (D=3).
- Result stalled: res_ready=0 for 5 cycles while op_valid=1 → res_valid held 5 cycles, dp_en=0, op_ready=0, no beat lost or duplicated after release.
- cfg_valid (4'b0001) raised after beat 2 of a 4-beat accumulation:
  - beats 3–4 still accepted and cfg_ready stays 0;
  - then DRAIN, cfg_ready=1 only after the result fires;
  - dp_cfg=4'b0001 the next cycle;
  - the next beat carries dp_acc_clr=1.
- Back-to-back single-beat accumulations (op_last=1 every cycle) → dp_acc_clr=1 every cycle, res_valid every cycle from t+3, throughput 1/cycle.
- rst asserted with 2 beats in flight → next cycle res_valid=0, busy=0, dp_cfg=0, IDLE. en=0 for 3 cycles mid-stream → no state change, res_valid timing shifted by exactly 3 cycles.
